nios2_gpio_bank: RTL and testbench

NIOS2_GPIO_BANK -- requirements
Module: nios2_gpio_bank

---
 rtl/nios2_gpio_bank.sv | 134 +++++++++++++
 tb/tb_nios2_gpio_bank.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/nios2_gpio_bank.sv
// Avalon-MM GPIO bank: data_out with set/clear aliases and a synchronised input port.
// Define NIOS2_GPIO_IRQ_EN to add the irqmask, edge-capture and interrupt logic.
module nios2_gpio_bank #(
  parameter int          WIDTH       = 16,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter int          EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

  logic             wr_s;
  logic [WIDTH-1:0] wdata_s;
  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] sync_meta_r;
  logic [WIDTH-1:0] in_sync_r;
  logic [31:0]      rd_s;
  logic             unused_wdata;

  assign wr_s         = chipselect & ~write_n;
  assign wdata_s      = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign out_port     = data_out_r;
  assign readdata     = rd_s;

  // Output data register with direct, set-bits and clear-bits write aliases
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_r <= RST_VAL;
    end else if (wr_s) begin
      case (address)
        3'd0:    data_out_r <= wdata_s;
        3'd4:    data_out_r <= data_out_r | wdata_s;
        3'd5:    data_out_r <= data_out_r & ~wdata_s;
        default: data_out_r <= data_out_r;
      endcase
    end else begin
      data_out_r <= data_out_r;
    end
  end

  // Two-flop synchroniser for the asynchronous input pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta_r <= {WIDTH{1'b0}};
      in_sync_r   <= {WIDTH{1'b0}};
    end else begin
      sync_meta_r <= in_port;
      in_sync_r   <= sync_meta_r;
    end
  end

`ifdef NIOS2_GPIO_IRQ_EN
  logic [WIDTH-1:0] irqmask_r;
  logic [WIDTH-1:0] edgecap_r;
  logic [WIDTH-1:0] in_prev_r;
  logic [1:0]       arm_cnt_r;
  logic             irq_r;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;

  function automatic logic [WIDTH-1:0] edge_detect(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] prev);
    case (EDGE_TYPE)
      0:       return cur & ~prev;
      1:       return ~cur & prev;
      2:       return cur ^ prev;
      default: return cur & ~prev;
    endcase
  endfunction

  // Edge events are masked until the synchroniser has filled after reset
  always_comb begin
    edge_s = {WIDTH{1'b0}};
    clr_s  = {WIDTH{1'b0}};
    if (arm_cnt_r == 2'd3) begin
      edge_s = edge_detect(in_sync_r, in_prev_r);
    end else begin
      edge_s = {WIDTH{1'b0}};
    end
    if (wr_s && (address == 3'd3)) begin
      clr_s = wdata_s;
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
  end

  // Arm counter, edge history, sticky capture (set beats clear), mask and irq
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt_r <= 2'd0;
      in_prev_r <= {WIDTH{1'b0}};
      edgecap_r <= {WIDTH{1'b0}};
      irqmask_r <= {WIDTH{1'b0}};
      irq_r     <= 1'b0;
    end else begin
      arm_cnt_r <= (arm_cnt_r == 2'd3) ? arm_cnt_r : arm_cnt_r + 2'd1;
      in_prev_r <= in_sync_r;
      edgecap_r <= (edgecap_r & ~clr_s) | edge_s;
      irqmask_r <= (wr_s && (address == 3'd2)) ? wdata_s : irqmask_r;
      irq_r     <= |(edgecap_r & irqmask_r);
    end
  end

  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif

  // Zero-wait-state read mux, zero-extended above WIDTH
  always_comb begin
    rd_s = 32'd0;
    case (address)
      3'd0:    rd_s[WIDTH-1:0] = data_out_r;
      3'd1:    rd_s[WIDTH-1:0] = in_sync_r;
`ifdef NIOS2_GPIO_IRQ_EN
      3'd2:    rd_s[WIDTH-1:0] = irqmask_r;
      3'd3:    rd_s[WIDTH-1:0] = edgecap_r;
`endif
      default: rd_s = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_nios2_gpio_bank.sv
// Randomised bench for nios2_gpio_bank: three instances (rising, falling, either edge)
// share one bus and are compared against a time-indexed reference model.
module tb_nios2_gpio_bank;

`ifdef NIOS2_GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [15:0] RST_VAL = 16'h00A5;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [15:0] in_port;
  logic [31:0] rd  [3];
  logic [15:0] op  [3];
  logic        irqv[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    nios2_gpio_bank #(.WIDTH(16), .RESET_VALUE(32'h0000_00A5), .EDGE_TYPE(g)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd[g]),
      .in_port(in_port), .out_port(op[g]), .irq(irqv[g]));
  end

  // reference model state
  logic [15:0] m_data, m_mask, m_sync;
  logic [15:0] m_ec [3];
  logic        m_irq[3];
  logic [15:0] hist[$];   // in_port value sampled at each edge since reset release
  int          checks = 0;
  int          passed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] edge_of(input int k, input logic [15:0] newer,
                                          input logic [15:0] older);
    if (k == 0) return newer & ~older;
    else if (k == 1) return ~newer & older;
    else return newer ^ older;
  endfunction

  function automatic logic [31:0] model_read(input int k, input logic [2:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a == 3'd0) r[15:0] = m_data;
    else if (a == 3'd1) r[15:0] = m_sync;
    else if (a == 3'd2 && IRQ_EN) r[15:0] = m_mask;
    else if (a == 3'd3 && IRQ_EN) r[15:0] = m_ec[k];
    return r;
  endfunction

  task automatic model_reset();
    m_data = RST_VAL; m_mask = 16'h0; m_sync = 16'h0;
    for (int k = 0; k < 3; k++) begin m_ec[k] = 16'h0; m_irq[k] = 1'b0; end
    hist.delete();
  endtask

  // expected state after the coming clock edge, from the inputs now on the bus
  task automatic model_step();
    int n;
    logic wr;
    logic [15:0] wd, clr, ed;
    hist.push_back(in_port);
    n  = hist.size();
    wr = chipselect & ~write_n;
    wd = writedata[15:0];
    for (int k = 0; k < 3; k++) begin
      m_irq[k] = IRQ_EN && ((m_ec[k] & m_mask) != 16'h0);
      clr = (wr && address == 3'd3) ? wd : 16'h0;
      // pin change before edge j is seen by the capture at edge j+2, once armed (edge 4+)
      ed  = (n >= 4) ? edge_of(k, hist[n-3], hist[n-4]) : 16'h0;
      if (IRQ_EN) m_ec[k] = (m_ec[k] & ~clr) | ed;
    end
    if (IRQ_EN && wr && address == 3'd2) m_mask = wd;
    if (wr && address == 3'd0) m_data = wd;
    if (wr && address == 3'd4) m_data = m_data | wd;
    if (wr && address == 3'd5) m_data = m_data & ~wd;
    m_sync = (n >= 2) ? hist[n-2] : 16'h0;
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("%s.rd[%0d]@%0d", ph, k, address), rd[k], model_read(k, address));
      check_val($sformatf("%s.out_port[%0d]", ph, k), {16'h0, op[k]}, {16'h0, m_data});
      check_val($sformatf("%s.irq[%0d]", ph, k), {31'h0, irqv[k]}, {31'h0, m_irq[k]});
    end
  endtask

  task automatic cyc(input string ph, input logic [2:0] a, input logic cs, input logic wn,
                     input logic [31:0] wd, input logic [15:0] ip);
    @(negedge clk);
    address = a; chipselect = cs; write_n = wn; writedata = wd; in_port = ip;
    model_step();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic wr_reg(input string ph, input logic [2:0] a, input logic [31:0] wd,
                        input logic [15:0] ip);
    cyc(ph, a, 1'b1, 1'b0, wd, ip);
  endtask

  task automatic rd_reg(input string ph, input logic [2:0] a, input logic [15:0] ip);
    cyc(ph, a, 1'b0, 1'b1, 32'h0, ip);
  endtask

  initial begin
    logic [15:0] ip;
    // reset with all inputs high: synchroniser fill must not capture anything
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = 16'hFFFF;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) rd_reg("fill", 3'd3, 16'hFFFF);
    rd_reg("sync", 3'd1, 16'hFFFF);

    // falling edge on bit 0
    for (int i = 0; i < 4; i++) rd_reg("fall", 3'd3, 16'hFFFE);
    wr_reg("w1c", 3'd3, 32'h0000_FFFF, 16'hFFFE);
    rd_reg("w1c_rd", 3'd3, 16'hFFFE);

    // direct write, set and clear aliases
    wr_reg("wr0", 3'd0, 32'hFFFF_1234, 16'hFFFE);
    rd_reg("rd0", 3'd0, 16'hFFFE);
    wr_reg("set", 3'd4, 32'h0000_0F00, 16'hFFFE);
    rd_reg("rd4", 3'd4, 16'hFFFE);
    wr_reg("clr", 3'd5, 32'h0000_0034, 16'hFFFE);
    rd_reg("rd5", 3'd5, 16'hFFFE);
    for (int a = 6; a < 8; a++) wr_reg("hole", 3'(a), 32'hFFFF_FFFF, 16'hFFFE);

    // masked rising edge on bit 0 raises irq, write-1-to-clear drops it
    wr_reg("mask", 3'd2, 32'h0000_0001, 16'hFFFE);
    for (int i = 0; i < 5; i++) rd_reg("rise", 3'd3, 16'hFFFF);
    wr_reg("ack", 3'd3, 32'h0000_0001, 16'hFFFF);
    rd_reg("ack_rd", 3'd3, 16'hFFFF);
    rd_reg("ack_rd2", 3'd3, 16'hFFFF);

    // new edge on bit 2 coincident with its clear: capture wins
    for (int i = 0; i < 4; i++) rd_reg("b2lo", 3'd3, 16'hFFFB);
    wr_reg("b2ack", 3'd3, 32'h0000_FFFF, 16'hFFFB);
    rd_reg("b2hi", 3'd3, 16'hFFFF);
    rd_reg("b2hi", 3'd3, 16'hFFFF);
    wr_reg("b2race", 3'd3, 32'h0000_0004, 16'hFFFF);
    rd_reg("b2keep", 3'd3, 16'hFFFF);

    // randomised traffic
    ip = in_port;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) ip = 16'($urandom);
      else ip = ip ^ (16'h1 << $urandom_range(0, 15));
      cyc("rand", 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom, ip);
    end

    // asynchronous reset mid-cycle with a write in flight
    @(posedge clk);
    #2;
    address = 3'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h0000_5A5A;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("midrst");
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ip = 16'($urandom);
      cyc("post", 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom, ip);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
